nn_feeder: RTL
==============

NN_FEEDER -- requirements
Module: nn_feeder

Interface
REQ-001 Parameter BYTES_PER_BLK, default 20: bytes packed per block, one per output lane.
REQ-002 Parameter IN_BLKS, default 50: input-feature blocks per frame.
REQ-003 Parameter HID_N, default 100; HID_BLKS, default 51: hidden neurons, and weight+bias blocks per hidden neuron.
REQ-004 Parameter OUT_N, default 2; OUT_BLKS, default 6: output neurons, and weight+bias blocks per output neuron.
REQ-005 Port clk  input  1: single clock; all logic on the rising edge.
REQ-006 Port reset  input  1: reset is synchronous and active-low (low while sampled at a clk rising edge resets the block).
REQ-007 Port abort  input  1: synchronous frame abort, active-high.
REQ-008 Port din  input  8: byte stream in, frame order.
REQ-009 Port din_valid  input  1; din_ready  output  1: byte handshake. A byte transfers on a cycle where both are high.
REQ-010 Port blk_data  output  160: packed block. Lane k (1..20) is at bits [8k-1:8k-8] and feeds the consumer port ink.
REQ-011 Port blk_count  output  8: block index within the current segment; drives the consumer count port.
REQ-012 Port blk_valid  input/output: blk_valid is an output, width 1; blk_ready is an input, width 1. Block handshake. A block transfers when both are high.
REQ-013 Port phase  output  2: segment of the held block. 0 = input, 1 = hidden, 2 = output.
REQ-014 Port neuron_idx  output  7: neuron number of the held block (0 in the input phase).
REQ-015 Port blk_last  output  1: the held block is the final block of the frame.
REQ-016 Port frame_done  output  1: one-cycle pulse after the final block transfers.

Function
REQ-017 The byte-lane index bidx (0..19) SHALL be handled as follows:
- An accepted byte with bidx<19 writes lane bidx+1, and bidx increments.
- An accepted byte with bidx=19 loads the output register with that byte in lane 20 and the other 19 lanes from the packer, sets blk_valid, and resets bidx to 0.
REQ-018 din_ready SHALL equal (bidx!=19) OR (blk_valid=0) OR (blk_ready=1). Acceptance of the 20th byte and transfer of the previous block in the same cycle is permitted with no bubble.
REQ-019 Latency: the 20th byte accepted at edge t SHALL make blk_valid high after edge t. The block SHALL be held stable until it transfers.
REQ-020 On a block transfer with no new load, blk_valid SHALL clear at the next edge. Data and tags SHALL hold until reloaded.
REQ-021 The FSM SHALL have states S_IN, S_HID, S_OUT. Block tags (blk_count, phase, neuron_idx, blk_last) SHALL be captured into the output register at load, from the sequencing counters.
REQ-022 In S_IN, blk_count SHALL run 0..IN_BLKS-1. Loading block IN_BLKS-1 SHALL move the sequencer to S_HID with neuron 0 and count 0.
REQ-023 In S_HID, count SHALL run 0..HID_BLKS-1 per neuron:
- At count HID_BLKS-1, the neuron index increments and count resets to 0.
- At neuron HID_N-1, count HID_BLKS-1, the sequencer moves to S_OUT with neuron 0.
REQ-024 In S_OUT, count SHALL run 0..OUT_BLKS-1 per neuron. The block at neuron OUT_N-1, count OUT_BLKS-1 SHALL be tagged blk_last=1, and the sequencer then returns to S_IN with counters 0.
REQ-025 Frame size SHALL be 50 + 100*51 + 2*6 = 5162 blocks = 103240 bytes.
REQ-026 frame_done SHALL pulse high for exactly one cycle, in the cycle after a blk_last block transfers.
REQ-027 abort=1 at an edge SHALL have the following effects:
- Clear bidx, blk_valid, and all counters.
- Force S_IN.
- Suppress frame_done.
- Discard any byte offered in that cycle; abort wins over a simultaneous din or blk transfer.
REQ-028 No byte SHALL be lost or duplicated under any blk_ready back-pressure pattern.

Reset
REQ-029 While reset=0 at an edge, the block SHALL set:
- din_ready=0 for that cycle, and 1 from the following cycle.
- blk_valid=0, blk_data=0, blk_count=0, phase=0, neuron_idx=0, blk_last=0, frame_done=0.
- bidx=0, state S_IN.
REQ-030 Reset SHALL take precedence over abort and over all handshakes. Reset mid-frame SHALL discard the partial frame.

Verification
REQ-031 Stream bytes 0x00..0x13 with blk_ready=1 -> one block with lane1=0x00 and lane20=0x13, blk_count=0, phase=0; valid for exactly 1 cycle after the 20th byte.
REQ-032 Send a full frame of 103240 bytes -> 5162 blocks. Check these transitions:
- (phase 0, count 49) -> (1, 0, neuron 0).
- (1, 50, neuron 99) -> (2, 0, neuron 0).
- Last block at (2, 5, neuron 1) with blk_last=1.
- frame_done one cycle later.
REQ-033 Hold blk_ready=0 for 30 cycles while din_valid=1 -> din_ready drops when bidx=19. blk_data stays stable. After release, bytes resume with no loss or duplication.
REQ-034 Abort after 1000 bytes -> blk_valid=0 next cycle. The next 20 bytes give blk_count=0, phase=0.
REQ-035 Drive reset=0 mid-block at bidx=7 -> all outputs take their REQ-029 values. The next 20 bytes form block 0 starting at lane 1.
REQ-036 Two back-to-back frames -> the second frame's tags repeat the first frame's exactly, and frame_done pulses twice.

Source files
------------

// File: rtl/nn_feeder_if.sv
// Byte-stream and block-stream handshake bundle for nn_feeder.
// master is the feeder's view; slave is the producer/consumer environment.
interface nn_feeder_if #(
  parameter int BYTES_PER_BLK = 20
);
  logic [7:0]                 din;
  logic                       din_valid;
  logic                       din_ready;
  logic [8*BYTES_PER_BLK-1:0] blk_data;
  logic [7:0]                 blk_count;
  logic                       blk_valid;
  logic                       blk_ready;
  logic [1:0]                 phase;
  logic [6:0]                 neuron_idx;
  logic                       blk_last;
  logic                       frame_done;

  modport master (
    input  din, din_valid, blk_ready,
    output din_ready, blk_data, blk_count, blk_valid, phase, neuron_idx,
           blk_last, frame_done
  );

  modport slave (
    output din, din_valid, blk_ready,
    input  din_ready, blk_data, blk_count, blk_valid, phase, neuron_idx,
           blk_last, frame_done
  );
endinterface

// File: rtl/nn_feeder.sv
// Packs a byte stream into wide blocks and tags each block with its segment
// (input / hidden / output), neuron number and index within the neuron.
module nn_feeder #(
  parameter int BYTES_PER_BLK = 20,
  parameter int IN_BLKS       = 50,
  parameter int HID_N         = 100,
  parameter int HID_BLKS      = 51,
  parameter int OUT_N         = 2,
  parameter int OUT_BLKS      = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        abort,
  nn_feeder_if.master bus
);

  localparam int W  = 8 * BYTES_PER_BLK;
  localparam int BW = (BYTES_PER_BLK > 1) ? $clog2(BYTES_PER_BLK) : 1;

  localparam logic [BW-1:0] LAST_LANE = BW'(BYTES_PER_BLK - 1);
  localparam logic [7:0]    IN_LAST   = 8'(IN_BLKS - 1);
  localparam logic [7:0]    HID_LAST  = 8'(HID_BLKS - 1);
  localparam logic [7:0]    OUT_LAST  = 8'(OUT_BLKS - 1);
  localparam logic [6:0]    HID_NLAST = 7'(HID_N - 1);
  localparam logic [6:0]    OUT_NLAST = 7'(OUT_N - 1);

  // Encoding doubles as the phase tag driven to the consumer.
  typedef enum logic [1:0] {
    S_IN  = 2'd0,
    S_HID = 2'd1,
    S_OUT = 2'd2
  } state_e;

  state_e state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [6:0] nrn_q, nrn_d;

  logic [BW-1:0] bidx_q, bidx_d;
  logic [BYTES_PER_BLK-2:0][7:0] pack_q, pack_d;

  logic [W-1:0] data_q, data_d;
  logic         valid_q, valid_d;
  logic [7:0]   count_q, count_d;
  logic [1:0]   phase_q, phase_d;
  logic [6:0]   neuron_q, neuron_d;
  logic         last_q, last_d;
  logic         frame_done_q, frame_done_d;

  logic din_ready;
  logic at_last_lane;
  logic accept;
  logic load;
  logic xfer;

  // The 20th byte may enter while the held block leaves in the same cycle.
  assign at_last_lane = (bidx_q == LAST_LANE);
  assign din_ready    = reset & (~at_last_lane | ~valid_q | bus.blk_ready);
  assign accept       = bus.din_valid & din_ready & ~abort;
  assign load         = accept & at_last_lane;
  assign xfer         = valid_q & bus.blk_ready;

  // NOTE: every variable gets its hold value before any branch, so no path
  // through this block leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    nrn_d        = nrn_q;
    bidx_d       = bidx_q;
    pack_d       = pack_q;
    data_d       = data_q;
    valid_d      = valid_q;
    count_d      = count_q;
    phase_d      = phase_q;
    neuron_d     = neuron_q;
    last_d       = last_q;
    frame_done_d = 1'b0;

    if (abort) begin
      // Abort beats any simultaneous byte or block transfer; tags/data hold.
      state_d = S_IN;
      cnt_d   = '0;
      nrn_d   = '0;
      bidx_d  = '0;
      valid_d = 1'b0;
    end else begin
      frame_done_d = xfer & last_q;
      if (xfer) valid_d = 1'b0;

      if (accept && !at_last_lane) begin
        pack_d[bidx_q] = bus.din;
        bidx_d         = bidx_q + BW'(1);
      end

      if (load) begin
        bidx_d   = '0;
        valid_d  = 1'b1;
        data_d   = {bus.din, pack_q};
        count_d  = cnt_q;
        phase_d  = state_q;
        neuron_d = nrn_q;
        last_d   = (state_q == S_OUT) && (nrn_q == OUT_NLAST) &&
                   (cnt_q == OUT_LAST);

        unique case (state_q)
          S_IN: begin
            if (cnt_q == IN_LAST) begin
              state_d = S_HID;
              cnt_d   = '0;
              nrn_d   = '0;
            end else begin
              cnt_d = cnt_q + 8'd1;
            end
          end
          S_HID: begin
            if (cnt_q == HID_LAST) begin
              cnt_d = '0;
              if (nrn_q == HID_NLAST) begin
                state_d = S_OUT;
                nrn_d   = '0;
              end else begin
                nrn_d = nrn_q + 7'd1;
              end
            end else begin
              cnt_d = cnt_q + 8'd1;
            end
          end
          S_OUT: begin
            if (cnt_q == OUT_LAST) begin
              cnt_d = '0;
              if (nrn_q == OUT_NLAST) begin
                state_d = S_IN;
                nrn_d   = '0;
              end else begin
                nrn_d = nrn_q + 7'd1;
              end
            end else begin
              cnt_d = cnt_q + 8'd1;
            end
          end
          default: begin
            state_d = S_IN;
            cnt_d   = '0;
            nrn_d   = '0;
          end
        endcase
      end
    end
  end

  // NOTE: non-blocking assignments here so every flop samples the pre-edge
  // values computed above, independent of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= S_IN;
      cnt_q        <= '0;
      nrn_q        <= '0;
      bidx_q       <= '0;
      data_q       <= '0;
      valid_q      <= 1'b0;
      count_q      <= '0;
      phase_q      <= '0;
      neuron_q     <= '0;
      last_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      nrn_q        <= nrn_d;
      bidx_q       <= bidx_d;
      data_q       <= data_d;
      valid_q      <= valid_d;
      count_q      <= count_d;
      phase_q      <= phase_d;
      neuron_q     <= neuron_d;
      last_q       <= last_d;
      frame_done_q <= frame_done_d;
    end
  end

  // NOTE: the packer lanes are not reset: bidx restarts at 0 after reset or
  // abort, so every lane is rewritten before it can reach the output register.
  always_ff @(posedge clk) begin
    pack_q <= pack_d;
  end

  assign bus.din_ready  = din_ready;
  assign bus.blk_data   = data_q;
  assign bus.blk_count  = count_q;
  assign bus.blk_valid  = valid_q;
  assign bus.phase      = phase_q;
  assign bus.neuron_idx = neuron_q;
  assign bus.blk_last   = last_q;
  assign bus.frame_done = frame_done_q;

endmodule
